// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready request and response ports.
// Define MULDIV_EARLY_OUT_EN to end a multiply early once the remaining multiplier bits are zero.
module rv_muldiv_iter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // mul: acc=product, opa=shifted multiplicand, opb=multiplier; div: acc=remainder, opa=divisor, opb=dividend/quotient
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] step_acc, step_opa, prod_fix;
    logic [XLEN-1:0]   step_opb, quo_fix, rem_fix, fin;
    logic [XLEN:0]     rem_t;
    logic              last_iter;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

    // Operand signedness and magnitudes at accept
    always_comb begin
        a_signed = !(req_op == 3'b011 || req_op == 3'b101 || req_op == 3'b111);
        b_signed = a_signed && (req_op != 3'b010);
        sa       = a_signed && req_a[XLEN-1];
        sb       = b_signed && req_b[XLEN-1];
        abs_a    = sa ? -req_a : req_a;
        abs_b    = sb ? -req_b : req_b;
    end

    // One CALC cycle of datapath work plus the final sign fix and result select
    always_comb begin
        step_acc = acc_q;
        step_opa = opa_q;
        step_opb = opb_q;
        rem_t    = '0;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            if (!op_q[2]) begin
                if (step_opb[0]) begin
                    step_acc = step_acc + step_opa;
                end
                step_opa = step_opa << 1;
                step_opb = step_opb >> 1;
            end else begin
                rem_t    = {step_acc[XLEN-1:0], step_opb[XLEN-1]};
                step_opb = step_opb << 1;
                if (rem_t >= {1'b0, step_opa[XLEN-1:0]}) begin
                    rem_t       = rem_t - {1'b0, step_opa[XLEN-1:0]};
                    step_opb[0] = 1'b1;
                end
                step_acc = {{XLEN{1'b0}}, rem_t[XLEN-1:0]};
            end
        end
        prod_fix = neg_q ? -step_acc : step_acc;
        quo_fix  = neg_q ? -step_opb : step_opb;
        rem_fix  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        case (op_q)
            3'b000:                 fin = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = quo_fix;
            default:                fin = rem_fix;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        last_iter = (cnt_q == CNT_W'(1)) || (!op_q[2] && (step_opb == '0));
`else
        last_iter = (cnt_q == CNT_W'(1));
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (!kill && req_valid) begin
                    op_d  = req_op;
                    neg_d = (req_op == 3'b110) ? sa : (sa ^ sb);
                    if (req_op[2] && (req_b == '0)) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = req_op[1] ? req_a : '1;
                    end else if (req_op[2] && !req_op[0] && (req_a == MIN_NEG) && (req_b == '1)) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = req_op[1] ? '0 : req_a;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(N);
                        acc_d   = '0;
                        opa_d   = {{XLEN{1'b0}}, req_op[2] ? abs_b : abs_a};
                        opb_d   = req_op[2] ? abs_a : abs_b;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    opa_d = step_opa;
                    opb_d = step_opb;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = fin;
                    end
                end
            end
            S_DONE: begin
                if (kill || resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: doc/rv_muldiv_iter.md
Name: rv_muldiv_iter

Overview:
Iterative RV32M/RV64M multiply/divide unit. It replaces the single-cycle combinational MUL/DIV paths in the datapath ALU so the core meets timing. The core issues an M-extension op over a valid/ready request port and stalls until the result returns on a valid/ready response port. Radix is parametrised, and the unit has a kill input for pipeline flush.

Parameters:
XLEN, 32, operand/result width; legal values 32, 64.
BITS_PER_CYCLE, 1, multiplier/quotient bits retired per CALC cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request; high iff state==IDLE
req_op  in  3  funct3 of the M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a  in  XLEN  rs1 operand
req_b  in  XLEN  rs2 operand
kill  in  1  abort the in-flight op
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts the result
resp_data  out  XLEN  result
busy  out  1  high in CALC or DONE

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high. On reset: state=IDLE, resp_valid=0, resp_data=0, busy=0, req_ready=1.
- Reset mid-operation: the op is discarded and no response is produced.
- States: IDLE, CALC, DONE. N = XLEN/BITS_PER_CYCLE.
- IDLE: on req_valid && req_ready, the unit latches op, operands, and sign-fix flags.
  - Normal op: go to CALC with the iteration counter set to N.
  - Fast case: go directly to DONE with the result loaded.
- Fast cases, applied to divide ops only:
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow, i.e. DIV/REM with a=most-negative and b=all-ones: DIV returns a; REM returns 0.
- CALC:
  - Multiply: shift-add over BITS_PER_CYCLE multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring divide producing BITS_PER_CYCLE quotient bits per cycle.
  - Signed ops operate on magnitudes. MULHSU treats only a as signed.
  - The counter decrements each cycle. When it reaches 0, apply the final sign fix: the quotient is negated if signs differ; the remainder takes the sign of a. Then go to DONE.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Latency: request handshake in cycle c gives resp_valid high from cycle c+N+1. Fast cases give resp_valid from cycle c+1.
- DONE: resp_valid=1 and resp_data holds stable until resp_ready. On resp_valid && resp_ready, go to IDLE. req_ready rises the next cycle; there is no same-cycle back-to-back accept.
- kill:
  - In CALC or DONE: go to IDLE next cycle and clear resp_valid. The result is dropped.
  - In IDLE: takes priority over req_valid, so no accept happens that cycle.
- resp_data keeps its last value in IDLE. It is only meaningful while resp_valid is high.
- Operand inputs are sampled only at accept; they may change during CALC without effect.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: in multiply CALC, if the remaining unshifted multiplier bits are all zero, the final fix is applied that cycle and the unit moves to DONE. Multiply latency is then ceil((msb_index(|b|)+1)/BITS_PER_CYCLE)+1 cycles, with a minimum of 2 when b==0. Divide latency is unchanged.
- Undefined: fixed N+1 latency for all non-fast ops.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD, XLEN=32, BPC=1 -> resp_data=0xFFFFFFEB; resp_valid first high exactly 33 cycles after the accept cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Repeat with BPC=2 and BPC=4; latencies must be 17 and 9 cycles.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each must show resp_valid in the cycle after accept.
- Hold resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready=0; then pulse resp_ready -> IDLE next cycle.
- Assert kill 10 cycles into a DIV -> IDLE next cycle, no resp_valid ever. Assert rst mid-MUL -> all outputs return to reset values. A following MUL 3*4 -> 12.
